// File: rtl/card_pkg.sv
// Shared constants and types for the card blitter.
package card_pkg;

  localparam int unsigned CARD_W   = 16;
  localparam int unsigned CARD_H   = 32;
  localparam int unsigned SCREEN_W = 256;
  localparam int unsigned SCREEN_H = 240;

  typedef logic [2:0]  color_t;
  typedef logic [8:0]  card_addr_t;
  typedef logic [15:0] fb_addr_t;

  localparam color_t     TRANSP_COLOR = 3'b000;
  localparam card_addr_t CARD_LAST    = card_addr_t'(CARD_W * CARD_H - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} blit_state_t;

  typedef struct packed {
    color_t     pix;
    logic [3:0] col;
    logic [4:0] row;
  } skid_entry_t;

endpackage

// File: rtl/card_blit_if.sv
// Request, card-memory and framebuffer signals of the card blitter.
interface card_blit_if;
  import card_pkg::*;

  logic       start;
  logic [7:0] x_pos;
  logic [7:0] y_pos;
  logic       busy;
  logic       done;
  logic       card_re;
  card_addr_t card_rAddr;
  color_t     card_dataOut;
  logic       fb_we;
  fb_addr_t   fb_addr;
  color_t     fb_data;
  logic       fb_grant;

  modport master (
    input  start, x_pos, y_pos, card_dataOut, fb_grant,
    output busy, done, card_re, card_rAddr, fb_we, fb_addr, fb_data
  );

  modport slave (
    output start, x_pos, y_pos, card_dataOut, fb_grant,
    input  busy, done, card_re, card_rAddr, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/card_blit_skid.sv
// Two-entry FIFO holding card pixels returned by the registered-read memory.
module card_blit_skid
  import card_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  skid_entry_t push_data,
  input  logic        pop,
  output skid_entry_t head,
  output logic [1:0]  count
);

  skid_entry_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/card_blit_ctrl.sv
// Copies a 16x32 card bitmap into the framebuffer with right/bottom clipping.
// Define TRANSPARENT_EN to skip pixels equal to TRANSP_COLOR.
module card_blit_ctrl
  import card_pkg::*;
(
  input logic         clock,
  input logic         reset,
  card_blit_if.master bus
);

  blit_state_t state_q, state_d;
  card_addr_t  rd_cnt_q, rd_cnt_d;
  logic [7:0]  x_q, y_q;
  logic        pend_q;
  logic [3:0]  pend_col_q;
  logic [4:0]  pend_row_q;

  skid_entry_t head;
  skid_entry_t push_data;
  logic [1:0]  skid_cnt;
  logic        head_valid, clipped, pop, issue;
  logic [8:0]  sx, sy;
  logic [2:0]  occ;

  assign push_data = '{pix: bus.card_dataOut, col: pend_col_q, row: pend_row_q};

  card_blit_skid u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (pend_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (skid_cnt)
  );

  assign head_valid = (skid_cnt != 2'd0);
  assign sx         = {1'b0, x_q} + {5'd0, head.col};
  assign sy         = {1'b0, y_q} + {4'd0, head.row};

  always_comb begin
    clipped = (sx >= 9'(SCREEN_W)) || (sy >= 9'(SCREEN_H));
`ifdef TRANSPARENT_EN
    if (head.pix == TRANSP_COLOR) clipped = 1'b1;
`endif
  end

  // Clipped pixels retire without waiting for the arbiter.
  assign pop         = head_valid && (clipped || bus.fb_grant);
  assign bus.fb_we   = head_valid && !clipped;
  assign bus.fb_addr = bus.fb_we ? {sy[7:0], sx[7:0]} : '0;
  assign bus.fb_data = bus.fb_we ? head.pix : '0;

  // Counting this cycle's pop keeps the pipe full at one pixel per clock.
  assign occ   = 3'(skid_cnt) + 3'(pend_q) - 3'(pop);
  assign issue = (state_q == READ) && (occ < 3'd2);

  assign bus.card_re    = issue;
  assign bus.card_rAddr = rd_cnt_q;
  assign bus.busy       = (state_q == READ) || (state_q == DRAIN);
  assign bus.done       = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 9'd1;
          if (rd_cnt_q == CARD_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_q && !head_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      pend_q     <= 1'b0;
      pend_col_q <= 4'd0;
      pend_row_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= issue;
      pend_col_q <= rd_cnt_q[3:0];
      pend_row_q <= rd_cnt_q[8:4];
      if (state_q == IDLE && bus.start) begin
        x_q <= bus.x_pos;
        y_q <= bus.y_pos;
      end
    end
  end

endmodule
